// File: rtl/cska_share_arb_pkg.sv
// Shared types and constants for the round-robin shared carry-skip adder.
// Optional overflow flag output is enabled with CSKA_SHARE_ARB_OVF_EN.
package cska_share_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 12;
  localparam int unsigned CSKA_BLK  = 4;

  // Requester tag width; at least one bit so a 1-requester tag stays legal.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cska_adder.sv
// Signed carry-skip adder wrapper: flat s_cska12 at 12 bits, generic otherwise.
module cska_adder
  import cska_share_arb_pkg::*;
#(
  parameter int unsigned W = WIDTH_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  if (W == 12) begin : g_flat
    s_cska12 u_add (
      .a  (a),
      .b  (b),
      .sum(sum)
    );
  end else begin : g_gen
    logic [W:0] ae, be, p, g;
    logic       carry, blk_p, blk_cin;

    always_comb begin
      ae      = {a[W-1], a};
      be      = {b[W-1], b};
      p       = ae ^ be;
      g       = ae & be;
      sum     = '0;
      carry   = 1'b0;
      blk_p   = 1'b0;
      blk_cin = 1'b0;
      for (int unsigned i = 0; i <= W; i++) begin
        if ((i % CSKA_BLK) == 0) begin
          blk_p   = 1'b1;
          blk_cin = carry;
        end
        sum[i] = p[i] ^ carry;
        blk_p  = blk_p & p[i];
        carry  = g[i] | (p[i] & carry);
        if (((i % CSKA_BLK) == CSKA_BLK - 1) && blk_p) carry = blk_cin;
      end
    end
  end

endmodule

// File: rtl/cska_rr_picker.sv
// Combinational round-robin picker: first valid lane at or after ptr, wrapping.
module cska_rr_picker
  import cska_share_arb_pkg::*;
#(
  parameter int unsigned N  = N_REQ_DEF,
  parameter int unsigned IW = id_w(N_REQ_DEF)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/s_cska12.sv
// Flat 12-bit signed carry-skip adder, 13-bit exact result, 4-bit skip blocks.
module s_cska12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [12:0] sum
);

  logic [12:0] ae, be, p, g;
  logic        carry, blk_p, blk_cin;

  always_comb begin
    ae      = {a[11], a};
    be      = {b[11], b};
    p       = ae ^ be;
    g       = ae & be;
    sum     = '0;
    carry   = 1'b0;
    blk_p   = 1'b0;
    blk_cin = 1'b0;
    for (int unsigned i = 0; i < 13; i++) begin
      if ((i % 4) == 0) begin
        blk_p   = 1'b1;
        blk_cin = carry;
      end
      sum[i] = p[i] ^ carry;
      blk_p  = blk_p & p[i];
      carry  = g[i] | (p[i] & carry);
      // Whole block propagating: carry-in bypasses the ripple chain.
      if (((i % 4) == 3) && blk_p) carry = blk_cin;
    end
  end

endmodule

// File: rtl/cska_share_arb.sv
// Round-robin arbiter sharing one signed carry-skip adder among N_REQ requesters.
// Define CSKA_SHARE_ARB_OVF_EN to add the registered rsp_ovf output.
module cska_share_arb
  import cska_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH:0]         rsp_sum
`ifdef CSKA_SHARE_ARB_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, ptr_nxt, idx, id_nxt;
  logic [N_REQ-1:0] grant;
  logic             slot_free, accept;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum, sum_nxt;
`ifdef CSKA_SHARE_ARB_OVF_EN
  logic             ovf_nxt;
`endif

  cska_rr_picker #(.N(N_REQ), .IW(ID_W)) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (idx)
  );

  // Grant only when the response slot can take a new result; never during reset.
  assign slot_free = (state == EMPTY) | rsp_ready;
  assign req_ready = grant & {N_REQ{slot_free & ~rst}};
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == FULL);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  cska_adder #(.W(WIDTH)) u_add (
    .a  (a_sel),
    .b  (b_sel),
    .sum(sum)
  );

  // Next-state and response register loads.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    id_nxt    = rsp_id;
    sum_nxt   = rsp_sum;
`ifdef CSKA_SHARE_ARB_OVF_EN
    ovf_nxt   = rsp_ovf;
`endif
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
    if (accept) begin
      sum_nxt = sum;
      id_nxt  = idx;
      if (32'(idx) == N_REQ - 1) ptr_nxt = '0;
      else                       ptr_nxt = idx + ID_W'(1);
`ifdef CSKA_SHARE_ARB_OVF_EN
      ovf_nxt = sum[WIDTH] ^ sum[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      rr_ptr  <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
`ifdef CSKA_SHARE_ARB_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rr_ptr  <= ptr_nxt;
      rsp_id  <= id_nxt;
      rsp_sum <= sum_nxt;
`ifdef CSKA_SHARE_ARB_OVF_EN
      rsp_ovf <= ovf_nxt;
`endif
    end
  end

endmodule
